// File: rtl/parallel_to_serial_lanes.sv
// parallel_to_serial_lanes: splits width-bit words into lanes-bit beats with a one-word holding buffer.
module parallel_to_serial_lanes #(
  parameter int width = 8,
  parameter int lanes = 1,
  parameter int msb_first = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             parallel_valid,
  output logic             parallel_ready,
  input  logic [width-1:0] parallel_data,
  output logic             serial_valid,
  input  logic             serial_ready,
  output logic [lanes-1:0] serial_data,
  output logic             serial_last,
  output logic             busy
);
  localparam int BEATS = width / lanes;
  localparam int CW = BEATS > 1 ? $clog2(BEATS) : 1;
  if (lanes < 1 || lanes > width || width % lanes != 0) begin : g_bad_params
    $error("parallel_to_serial_lanes: width must be a positive multiple of lanes");
  end
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [width-1:0] shift_q, shift_d, pend_q, pend_d;
  logic pend_valid_q, pend_valid_d;
  logic acc, s_hs, last_hs;
  assign serial_valid = state_q == SHIFT;
  assign serial_last = serial_valid && cnt_q == CW'(BEATS - 1);
  assign serial_data = serial_valid ? (msb_first != 0 ? shift_q[width-1 -: lanes] : shift_q[lanes-1:0]) : '0;
  assign parallel_ready = !rst && !pend_valid_q;
  assign busy = serial_valid || pend_valid_q;
  assign acc = parallel_valid && parallel_ready;
  assign s_hs = serial_valid && serial_ready;
  assign last_hs = s_hs && serial_last;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    shift_d = shift_q;
    pend_d = pend_q;
    pend_valid_d = pend_valid_q;
    if (last_hs && pend_valid_q) begin
      state_d = SHIFT;
      cnt_d = '0;
      shift_d = pend_q;
      pend_valid_d = 1'b0;
    end else if (acc && (state_q == IDLE || last_hs)) begin
      state_d = SHIFT;
      cnt_d = '0;
      shift_d = parallel_data;
    end else if (last_hs) begin
      state_d = IDLE;
      cnt_d = '0;
      shift_d = '0;
    end else if (s_hs) begin
      cnt_d = cnt_q + CW'(1);
      shift_d = msb_first != 0 ? shift_q << lanes : shift_q >> lanes;
    end
    // a word arriving while the shifter is mid-word waits in the buffer
    if (acc && state_q == SHIFT && !last_hs) begin
      pend_d = parallel_data;
      pend_valid_d = 1'b1;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      shift_q <= '0;
      pend_q <= '0;
      pend_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      shift_q <= shift_d;
      pend_q <= pend_d;
      pend_valid_q <= pend_valid_d;
    end
  end
endmodule
